// File: rtl/vector_sweep_ctrl_pkg.sv
// Shared definitions for the vector sweep controller: FSM encoding and the
// 16-bit response signature (MISR) polynomial.
package vector_sweep_ctrl_pkg;

  localparam int SIG_W = 16;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [SIG_W-1:0] SIG_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic             d);
    return {s[SIG_W-2:0], ^(s & SIG_TAPS)} ^ {{(SIG_W-1){1'b0}}, d};
  endfunction

endpackage

// File: rtl/sig_misr16.sv
// 16-bit single-input signature register; clr has priority over en.
module sig_misr16
  import vector_sweep_ctrl_pkg::*;
(
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CK or posedge reset) begin
    if (reset)    r_sig <= '0;
    else if (clr) r_sig <= '0;
    else if (en)  r_sig <= misr_next(r_sig, din);
  end

  assign sig = r_sig;

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweep: drives every NIN-bit vector in ascending order,
// waits SETTLE cycles, captures the response and emits it as a valid/ready record.
module vector_sweep_ctrl
  import vector_sweep_ctrl_pkg::*;
#(
  parameter int NIN    = 3,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  input  logic             rec_ready,
  output logic [NIN-1:0]   dut_in,
  output logic             busy,
  output logic             done,
  output logic             rec_valid,
  output logic [NIN-1:0]   rec_vec,
  output logic             rec_resp,
  output logic [SIG_W-1:0] sig
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [NIN-1:0] r_cnt;
  logic [7:0]     r_settle;
  logic [NIN-1:0] r_dut_in;
  logic           r_busy;
  logic           r_rec_valid;
  logic [NIN-1:0] r_rec_vec;
  logic           r_rec_resp;
  logic           w_last;
  logic           w_sig_clr;
  logic           w_sig_en;

  assign w_last    = &r_cnt;
  assign w_sig_clr = (r_state == ST_IDLE) && start;
  assign w_sig_en  = (r_state == ST_CAPTURE) && !abort;

  // NOTE: defaulting w_state_next before the case keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_APPLY;
      ST_APPLY:   w_state_next = ST_SETTLE;
      ST_SETTLE:  if (r_settle == '0) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_EMIT;
      ST_EMIT:    if (rec_ready) w_state_next = w_last ? ST_DONE : ST_APPLY;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
    // Abort beats everything, including an EMIT handshake in the same cycle.
    if (abort && (r_state != ST_IDLE)) w_state_next = ST_IDLE;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_dut_in    <= '0;
      r_busy      <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec_vec   <= '0;
      r_rec_resp  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_rec_valid <= (w_state_next == ST_EMIT);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_dut_in <= '0;
          end
        end
        ST_APPLY:  r_settle <= SETTLE_LOAD;
        ST_SETTLE: if (r_settle != '0) r_settle <= r_settle - 8'd1;
        ST_CAPTURE: begin
          if (!abort) begin
            r_rec_vec  <= r_cnt;
            r_rec_resp <= dut_out;
          end
        end
        ST_EMIT: begin
          // dut_in advances together with the counter so it is already valid in APPLY.
          if (rec_ready && !abort && !w_last) begin
            r_cnt    <= r_cnt + 1'b1;
            r_dut_in <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sig_misr16 u_sig (
    .CK    (CK),
    .reset (reset),
    .clr   (w_sig_clr),
    .en    (w_sig_en),
    .din   (dut_out),
    .sig   (sig)
  );

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign rec_valid = r_rec_valid;
  assign rec_vec   = r_rec_vec;
  assign rec_resp  = r_rec_resp;

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench for vector_sweep_ctrl: table of expected records plus
// hand-written stall, abort, reset and long-settle sequences.
module tb_vector_sweep_ctrl;

  logic        CK = 1'b0;
  logic        reset;
  logic        start, abort, rec_ready, force_one;
  logic [2:0]  dut_in, rec_vec;
  logic        busy, done, rec_valid, rec_resp, dut_out;
  logic [15:0] sig;

  logic        start4, abort4;
  logic [2:0]  dut_in4, rec_vec4;
  logic        busy4, done4, rec_valid4, rec_resp4, dut_out4;
  logic [15:0] sig4;

  assign dut_out  = force_one ? 1'b1 : ^dut_in;
  assign dut_out4 = ^dut_in4;

  always #5 CK = ~CK;

  vector_sweep_ctrl #(.NIN(3), .SETTLE(1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .dut_out(dut_out),
    .rec_ready(rec_ready), .dut_in(dut_in), .busy(busy), .done(done),
    .rec_valid(rec_valid), .rec_vec(rec_vec), .rec_resp(rec_resp), .sig(sig)
  );

  vector_sweep_ctrl #(.NIN(3), .SETTLE(4)) u_dut4 (
    .CK(CK), .reset(reset), .start(start4), .abort(abort4), .dut_out(dut_out4),
    .rec_ready(rec_ready), .dut_in(dut_in4), .busy(busy4), .done(done4),
    .rec_valid(rec_valid4), .rec_vec(rec_vec4), .rec_resp(rec_resp4), .sig(sig4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  int rec4_cnt = 0;

  always @(negedge CK) begin
    if (done)  done_cnt++;
    if (done4) done4_cnt++;
    if (rec_valid4 && rec_ready) rec4_cnt++;
  end

  typedef struct {
    logic [2:0] vec;
    logic       resp;
    int         stall;
  } rec_t;

  rec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge CK);
      cycles++;
    end while (!rec_valid && cycles < limit);
    if (!rec_valid) check("rec_valid timeout", {31'd0, rec_valid}, 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int cycles = 0;
    do begin
      @(negedge CK);
      cycles++;
    end while (!done && cycles < limit);
    check("done seen", {31'd0, done}, 32'd1);
  endtask

  // Consumes records first..last; returns the wait before the first record.
  task automatic run_records(input int first, input int last, input bit use_stall,
                             output int first_cyc);
    int cyc;
    first_cyc = 0;
    for (int i = first; i <= last; i++) begin
      wait_valid(20, cyc);
      if (i == first) first_cyc = cyc;
      check($sformatf("rec%0d vec", i), {29'd0, rec_vec}, {29'd0, tbl[i].vec});
      check($sformatf("rec%0d resp", i), {31'd0, rec_resp}, {31'd0, tbl[i].resp});
      if (use_stall && tbl[i].stall > 0) begin
        rec_ready = 1'b0;
        for (int k = 0; k < tbl[i].stall; k++) begin
          @(negedge CK);
          check($sformatf("stall%0d valid", k), {31'd0, rec_valid}, 32'd1);
          check($sformatf("stall%0d vec", k), {29'd0, rec_vec}, {29'd0, tbl[i].vec});
          check($sformatf("stall%0d resp", k), {31'd0, rec_resp}, {31'd0, tbl[i].resp});
        end
        rec_ready = 1'b1;
      end
    end
  endtask

  task automatic start_sweep();
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, d0, r0, d4, first_v;

    reset = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1; force_one = 1'b0;
    start4 = 1'b0; abort4 = 1'b0;

    // XOR-of-inputs responses; record 3 is stalled for 5 cycles when stalls are enabled.
    tbl[0] = '{3'd0, 1'b0, 0};
    tbl[1] = '{3'd1, 1'b1, 0};
    tbl[2] = '{3'd2, 1'b1, 0};
    tbl[3] = '{3'd3, 1'b0, 5};
    tbl[4] = '{3'd4, 1'b1, 0};
    tbl[5] = '{3'd5, 1'b0, 0};
    tbl[6] = '{3'd6, 1'b0, 0};
    tbl[7] = '{3'd7, 1'b1, 0};

    #12;
    check("rst dut_in",    {29'd0, dut_in},   32'd0);
    check("rst busy",      {31'd0, busy},     32'd0);
    check("rst done",      {31'd0, done},     32'd0);
    check("rst rec_valid", {31'd0, rec_valid}, 32'd0);
    check("rst rec_vec",   {29'd0, rec_vec},  32'd0);
    check("rst rec_resp",  {31'd0, rec_resp}, 32'd0);
    check("rst sig",       {16'd0, sig},      32'd0);
    @(negedge CK);
    reset = 1'b0;
    repeat (2) @(negedge CK);
    check("idle busy", {31'd0, busy}, 32'd0);

    // Abort in IDLE has no effect.
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    check("idle abort busy", {31'd0, busy}, 32'd0);

    // Full sweep, rec_ready always high.
    d0 = done_cnt;
    start_sweep();
    check("t1 busy", {31'd0, busy}, 32'd1);
    check("t1 dut_in", {29'd0, dut_in}, 32'd0);
    run_records(0, 7, 1'b0, cyc);
    check("t1 latency", 1 + cyc, 32'd4);
    wait_done(10);
    check("t1 sig", {16'd0, sig}, 32'h0069);
    @(negedge CK);
    check("t1 post busy", {31'd0, busy}, 32'd0);
    check("t1 post done", {31'd0, done}, 32'd0);
    check("t1 last dut_in", {29'd0, dut_in}, 32'd7);
    repeat (2) @(negedge CK);
    check("t1 done count", done_cnt - d0, 32'd1);

    // Full sweep with a 5-cycle stall on record 3.
    start_sweep();
    check("t2 sig cleared", {16'd0, sig}, 32'd0);
    run_records(0, 7, 1'b1, cyc);
    wait_done(10);
    check("t2 sig", {16'd0, sig}, 32'h0069);
    repeat (2) @(negedge CK);

    // Abort in SETTLE of vector 5.
    d0 = done_cnt;
    start_sweep();
    run_records(0, 4, 1'b0, cyc);
    @(negedge CK);
    check("t3 apply dut_in", {29'd0, dut_in}, 32'd5);
    @(negedge CK);
    check("t3 settle busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    check("t3 abort busy", {31'd0, busy}, 32'd0);
    check("t3 abort valid", {31'd0, rec_valid}, 32'd0);
    check("t3 abort sig", {16'd0, sig}, 32'h000D);
    repeat (3) @(negedge CK);
    check("t3 no done", done_cnt - d0, 32'd0);
    check("t3 sig frozen", {16'd0, sig}, 32'h000D);

    // Abort coinciding with the EMIT handshake of record 1.
    d0 = done_cnt;
    start_sweep();
    run_records(0, 1, 1'b0, cyc);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    check("t3b busy", {31'd0, busy}, 32'd0);
    check("t3b valid", {31'd0, rec_valid}, 32'd0);
    check("t3b dut_in", {29'd0, dut_in}, 32'd1);
    check("t3b sig", {16'd0, sig}, 32'h0001);
    repeat (3) @(negedge CK);
    check("t3b no done", done_cnt - d0, 32'd0);

    // Reset mid-EMIT, then a fresh complete sweep.
    start_sweep();
    run_records(0, 2, 1'b0, cyc);
    reset = 1'b1;
    #1;
    check("t4 dut_in",    {29'd0, dut_in},    32'd0);
    check("t4 busy",      {31'd0, busy},      32'd0);
    check("t4 done",      {31'd0, done},      32'd0);
    check("t4 rec_valid", {31'd0, rec_valid}, 32'd0);
    check("t4 rec_vec",   {29'd0, rec_vec},   32'd0);
    check("t4 rec_resp",  {31'd0, rec_resp},  32'd0);
    check("t4 sig",       {16'd0, sig},       32'd0);
    @(negedge CK);
    reset = 1'b0;
    repeat (3) @(negedge CK);
    check("t4 idle busy", {31'd0, busy}, 32'd0);
    start_sweep();
    run_records(0, 7, 1'b0, cyc);
    check("t4 latency", 1 + cyc, 32'd4);
    wait_done(10);
    check("t4 sig", {16'd0, sig}, 32'h0069);

    // dut_out tied high: eight shifts of 1 from 0.
    force_one = 1'b1;
    start_sweep();
    wait_done(100);
    check("t5 sig ones", {16'd0, sig}, 32'h00FF);
    force_one = 1'b0;
    repeat (2) @(negedge CK);

    // SETTLE=4 instance with start held high across the sweep.
    r0 = rec4_cnt;
    d4 = done4_cnt;
    first_v = 0;
    cyc = 0;
    @(negedge CK);
    start4 = 1'b1;
    do begin
      @(negedge CK);
      cyc++;
      if (rec_valid4 && first_v == 0) first_v = cyc;
    end while (!done4 && cyc < 200);
    check("t6 done seen", {31'd0, done4}, 32'd1);
    check("t6 first valid", first_v, 32'd7);
    check("t6 sweep length", cyc, 32'd57);
    check("t6 sig", {16'd0, sig4}, 32'h0069);
    @(negedge CK);
    check("t6 idle busy", {31'd0, busy4}, 32'd0);
    check("t6 records", rec4_cnt - r0, 32'd8);
    @(negedge CK);
    check("t6 restart busy", {31'd0, busy4}, 32'd1);
    check("t6 restart dut_in", {29'd0, dut_in4}, 32'd0);
    start4 = 1'b0;
    cyc = 0;
    do begin
      @(negedge CK);
      cyc++;
    end while (!done4 && cyc < 100);
    check("t6 second done", {31'd0, done4}, 32'd1);
    repeat (3) @(negedge CK);
    check("t6 done count", done4_cnt - d4, 32'd2);
    check("t6 total records", rec4_cnt - r0, 32'd16);
    check("t6 final busy", {31'd0, busy4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
